// File: rtl/and_port_pkg.sv
// Shared defaults for the and_port logic-gate primitive and its monitors.
package and_port_pkg;
    localparam int AND_PORT_WIDTH = 1;
    localparam int AND_PORT_CNT_W = 16;
endpackage

// File: rtl/and_port_if.sv
// Operand/result bundle for and_port; the master drives operands, the slave drives results.
interface and_port_if
    import and_port_pkg::*;
#(
    parameter int WIDTH = AND_PORT_WIDTH,
    parameter int CNT_W = AND_PORT_CNT_W
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             out_chg;
    logic [CNT_W-1:0] chg_count;

    // No handshake: operands are sampled every rising edge, results are always valid.
    modport master (
        output a, b,
        input  out, out_q, out_chg, chg_count
    );

    modport slave (
        input  a, b,
        output out, out_q, out_chg, chg_count
    );
endinterface

// File: rtl/and_port_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_r;
    logic             at_max;

    assign at_max = (count_r == {CNT_W{1'b1}});
    assign count  = count_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (inc && !at_max) begin
            count_r <= count_r + 1'b1;
        end
    end
endmodule

// File: rtl/and_port.sv
// Bitwise AND with combinational and registered results, plus change pulse and change counter.
module and_port
    import and_port_pkg::*;
#(
    parameter int WIDTH = AND_PORT_WIDTH,
    parameter int CNT_W = AND_PORT_CNT_W
) (
    input logic      clk,
    input logic      rst,
    and_port_if.slave port
);
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] out_q_r;
    logic             out_chg_r;
    logic             changed;
    logic [CNT_W-1:0] count;

    assign nxt      = port.a & port.b;
    assign port.out = nxt;

    // Compared against the current register, so the first edge after reset sees 0.
    assign changed = (nxt != out_q_r);

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q_r   <= '0;
            out_chg_r <= 1'b0;
        end else begin
            out_q_r   <= nxt;
            out_chg_r <= changed;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_chg_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (changed),
        .count (count)
    );

    assign port.out_q     = out_q_r;
    assign port.out_chg   = out_chg_r;
    assign port.chg_count = count;
endmodule

// File: tb/tb_and_port.sv
// Directed bench for and_port: truth table, latency, change detect, reset, saturation, vectors.
module tb_and_port;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    and_port_if #(.WIDTH(1), .CNT_W(16)) if1 ();
    and_port_if #(.WIDTH(1), .CNT_W(2))  if2 ();
    and_port_if #(.WIDTH(4), .CNT_W(16)) if4 ();

    and_port #(.WIDTH(1), .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .port(if1));
    and_port #(.WIDTH(1), .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .port(if2));
    and_port #(.WIDTH(4), .CNT_W(16)) dut4 (.clk(clk), .rst(rst), .port(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        if1.a = '0; if1.b = '0;
        if2.a = '0; if2.b = '0;
        if4.a = '0; if4.b = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (if1.out_q !== 1'b0 || if1.out_chg !== 1'b0 || if1.chg_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_w1: out_q=%b out_chg=%b cnt=%0d, want 0 0 0", if1.out_q, if1.out_chg, if1.chg_count);
        end
        vectors++;
        if (if4.out_q !== 4'b0000 || if4.out_chg !== 1'b0 || if4.chg_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_w4: out_q=%b out_chg=%b cnt=%0d, want 0000 0 0", if4.out_q, if4.out_chg, if4.chg_count);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] ab [4];
        logic       exp_out [4];
        ab = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp_out = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            if1.a = ab[i][1];
            if1.b = ab[i][0];
            #1;
            vectors++;
            if (if1.out !== exp_out[i]) begin
                miscompares++;
                $display("FAIL truth_%b: out=%b want %b", ab[i], if1.out, exp_out[i]);
            end
            #9;
        end
    endtask

    task automatic test_latency();
        do_reset();
        if1.a = 1'b1; if1.b = 1'b1;
        step();
        vectors++;
        if (if1.out_q !== 1'b1 || if1.out_chg !== 1'b1 || if1.chg_count !== 16'd1) begin
            miscompares++;
            $display("FAIL latency_first: out_q=%b out_chg=%b cnt=%0d, want 1 1 1", if1.out_q, if1.out_chg, if1.chg_count);
        end
        step();
        vectors++;
        if (if1.out_q !== 1'b1 || if1.out_chg !== 1'b0 || if1.chg_count !== 16'd1) begin
            miscompares++;
            $display("FAIL latency_hold: out_q=%b out_chg=%b cnt=%0d, want 1 0 1", if1.out_q, if1.out_chg, if1.chg_count);
        end
    endtask

    task automatic test_sequence();
        logic [1:0] ab [5];
        logic       exp_q [5];
        logic       exp_chg [5];
        ab      = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        exp_q   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_chg = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if1.a = ab[i][1];
            if1.b = ab[i][0];
            step();
            vectors++;
            if (if1.out_q !== exp_q[i] || if1.out_chg !== exp_chg[i]) begin
                miscompares++;
                $display("FAIL seq_%0d: out_q=%b out_chg=%b, want %b %b", i, if1.out_q, if1.out_chg, exp_q[i], exp_chg[i]);
            end
        end
        vectors++;
        if (if1.chg_count !== 16'd2) begin
            miscompares++;
            $display("FAIL seq_count: cnt=%0d want 2", if1.chg_count);
        end
    endtask

    task automatic test_reset_mid();
        // Continues from the sequence end (out_q=0, cnt=2): one more rise gives out_q=1, cnt=3.
        if1.a = 1'b1; if1.b = 1'b1;
        step();
        vectors++;
        if (if1.out_q !== 1'b1 || if1.chg_count !== 16'd3) begin
            miscompares++;
            $display("FAIL mid_setup: out_q=%b cnt=%0d, want 1 3", if1.out_q, if1.chg_count);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (if1.out !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_out_in_rst: out=%b want 1", if1.out);
        end
        step();
        vectors++;
        if (if1.out_q !== 1'b0 || if1.out_chg !== 1'b0 || if1.chg_count !== 16'd0 || if1.out !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: out_q=%b out_chg=%b cnt=%0d out=%b, want 0 0 0 1",
                     if1.out_q, if1.out_chg, if1.chg_count, if1.out);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (if1.out_q !== 1'b1 || if1.out_chg !== 1'b1 || if1.chg_count !== 16'd1) begin
            miscompares++;
            $display("FAIL mid_release: out_q=%b out_chg=%b cnt=%0d, want 1 1 1", if1.out_q, if1.out_chg, if1.chg_count);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [6];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        do_reset();
        if2.b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if2.a = (i % 2 == 0) ? 1'b1 : 1'b0;
            step();
            vectors++;
            if (if2.chg_count !== exp_cnt[i] || if2.out_chg !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_%0d: cnt=%0d out_chg=%b, want %0d 1", i, if2.chg_count, if2.out_chg, exp_cnt[i]);
            end
        end
    endtask

    task automatic test_vector();
        do_reset();
        if4.a = 4'b1100; if4.b = 4'b1010;
        #1;
        vectors++;
        if (if4.out !== 4'b1000) begin
            miscompares++;
            $display("FAIL vec_out1: out=%b want 1000", if4.out);
        end
        step();
        vectors++;
        if (if4.out_q !== 4'b1000 || if4.out_chg !== 1'b1 || if4.chg_count !== 16'd1) begin
            miscompares++;
            $display("FAIL vec_edge1: out_q=%b out_chg=%b cnt=%0d, want 1000 1 1", if4.out_q, if4.out_chg, if4.chg_count);
        end
        if4.b = 4'b1110;
        #1;
        vectors++;
        if (if4.out !== 4'b1100) begin
            miscompares++;
            $display("FAIL vec_out2: out=%b want 1100", if4.out);
        end
        step();
        vectors++;
        if (if4.out_q !== 4'b1100 || if4.out_chg !== 1'b1 || if4.chg_count !== 16'd2) begin
            miscompares++;
            $display("FAIL vec_edge2: out_q=%b out_chg=%b cnt=%0d, want 1100 1 2", if4.out_q, if4.out_chg, if4.chg_count);
        end
        step();
        vectors++;
        if (if4.out_chg !== 1'b0 || if4.chg_count !== 16'd2) begin
            miscompares++;
            $display("FAIL vec_hold: out_chg=%b cnt=%0d, want 0 2", if4.out_chg, if4.chg_count);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        if1.a = '0; if1.b = '0;
        if2.a = '0; if2.b = '0;
        if4.a = '0; if4.b = '0;
        test_reset();
        test_truth_table();
        test_latency();
        test_sequence();
        test_reset_mid();
        test_saturation();
        test_vector();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
